// File: rtl/key_generation_top.sv
// key_generation_top: batch Paillier key generation (n, g, lambda, mu) over RAM-held prime pairs.
// Shift-and-add multiply, then a binary extended-Euclid inverse taking one step per cycle.
module key_generation_top #(
    parameter int DATA_WIDTH     = 1024,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int FILE_SIZE      = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic                      done,
    input  logic [DATA_WIDTH/2-1:0]   p_din,
    input  logic [RAM_ADDR_WIDTH-1:0] p_wr_addr,
    input  logic                      p_wr_en,
    input  logic [DATA_WIDTH/2-1:0]   q_din,
    input  logic [RAM_ADDR_WIDTH-1:0] q_wr_addr,
    input  logic                      q_wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0] out_rd_addr,
    output logic [DATA_WIDTH-1:0]     u_dout,
    output logic [DATA_WIDTH-1:0]     n_dout,
    output logic [DATA_WIDTH-1:0]     g_dout,
    output logic [DATA_WIDTH-1:0]     lambda_dout
);
    localparam int DW = DATA_WIDTH;
    localparam int HW = DATA_WIDTH / 2;
    localparam int AW = RAM_ADDR_WIDTH;
    localparam int CW = $clog2(HW) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, MUL, INV, WRITE, DONE} state_t;

    state_t        state;
    logic [HW-1:0] p_ram [2**AW];
    logic [HW-1:0] q_ram [2**AW];
    logic [DW-1:0] n_ram [2**AW];
    logic [DW-1:0] g_ram [2**AW];
    logic [DW-1:0] l_ram [2**AW];
    logic [DW-1:0] u_ram [2**AW];
    logic [HW-1:0] p_rd, q_rd, q_sh, qm_sh;
    logic [DW-1:0] n_acc, l_acc, p_sh, pm_sh, u_val, a, b;
    logic [DW:0]   x1, x2, nn, x1_half, x2_half, x1_sub, x2_sub;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          first, start_q;

    // Coefficients stay in [0, n); halving an odd one first adds n, which needs the extra bit.
    always_comb begin
        nn      = {1'b0, n_acc};
        x1_half = x1[0] ? (x1 + nn) >> 1 : x1 >> 1;
        x2_half = x2[0] ? (x2 + nn) >> 1 : x2 >> 1;
        x1_sub  = x1 >= x2 ? x1 - x2 : x1 + nn - x2;
        x2_sub  = x2 >= x1 ? x2 - x1 : x2 + nn - x1;
    end

    always_ff @(posedge clock) begin
        if (p_wr_en) p_ram[p_wr_addr] <= p_din;
        if (q_wr_en) q_ram[q_wr_addr] <= q_din;
        p_rd <= p_ram[idx];
        q_rd <= q_ram[idx];
        if (state == WRITE) begin
            n_ram[idx] <= n_acc;
            g_ram[idx] <= n_acc + DW'(1);
            l_ram[idx] <= l_acc;
            u_ram[idx] <= u_val;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_dout      <= '0;
            g_dout      <= '0;
            lambda_dout <= '0;
            u_dout      <= '0;
        end else begin
            n_dout      <= n_ram[out_rd_addr];
            g_dout      <= g_ram[out_rd_addr];
            lambda_dout <= l_ram[out_rd_addr];
            u_dout      <= u_ram[out_rd_addr];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            first   <= 1'b0;
            start_q <= 1'b0;
            n_acc   <= '0;
            l_acc   <= '0;
            p_sh    <= '0;
            pm_sh   <= '0;
            q_sh    <= '0;
            qm_sh   <= '0;
            a       <= '0;
            b       <= '0;
            x1      <= '0;
            x2      <= '0;
            u_val   <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    first <= 1'b1;
                    state <= LOAD;
                end
                // A restart from DONE needs a fresh rising edge so a held start runs once.
                DONE: if (start && !start_q) begin
                    done  <= 1'b0;
                    idx   <= '0;
                    first <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    first <= 1'b0;
                    if (!first) begin
                        p_sh  <= DW'(p_rd);
                        pm_sh <= DW'(p_rd) - DW'(1);
                        q_sh  <= q_rd;
                        qm_sh <= q_rd - HW'(1);
                        n_acc <= '0;
                        l_acc <= '0;
                        cnt   <= '0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    n_acc <= n_acc + (q_sh[0] ? p_sh : '0);
                    l_acc <= l_acc + (qm_sh[0] ? pm_sh : '0);
                    p_sh  <= p_sh << 1;
                    pm_sh <= pm_sh << 1;
                    q_sh  <= q_sh >> 1;
                    qm_sh <= qm_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(HW - 1)) begin
                        first <= 1'b1;
                        state <= INV;
                    end
                end
                // Halving is only done while the other operand is odd, so gcd(a, b) is preserved
                // and both-even or a zero operand proves a common factor.
                INV: begin
                    first <= 1'b0;
                    if (first) begin
                        a  <= l_acc;
                        b  <= n_acc;
                        x1 <= (DW + 1)'(1);
                        x2 <= '0;
                        if (l_acc == '0 || n_acc <= DW'(1)) begin
                            u_val <= '0;
                            state <= WRITE;
                        end
                    end else if (a == DW'(1)) begin
                        u_val <= x1[DW-1:0];
                        state <= WRITE;
                    end else if (b == DW'(1)) begin
                        u_val <= x2[DW-1:0];
                        state <= WRITE;
                    end else if (a == '0 || b == '0 || (!a[0] && !b[0])) begin
                        u_val <= '0;
                        state <= WRITE;
                    end else if (!a[0]) begin
                        a  <= a >> 1;
                        x1 <= x1_half;
                    end else if (!b[0]) begin
                        b  <= b >> 1;
                        x2 <= x2_half;
                    end else if (a >= b) begin
                        a  <= a - b;
                        x1 <= x1_sub;
                    end else begin
                        b  <= b - a;
                        x2 <= x2_sub;
                    end
                end
                WRITE: begin
                    idx   <= idx + AW'(1);
                    first <= 1'b1;
                    if (idx == AW'(FILE_SIZE - 1)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_generation_top.sv
// tb_key_generation_top: checks the key-generation batch engine against an arithmetic reference
// (direct products, gcd and brute-force modular inverse) at a 16-bit key width.
module tb_key_generation_top;
    localparam int DW = 16;
    localparam int HW = 8;
    localparam int AW = 4;
    localparam int FS = 6;

    logic          clock = 1'b0;
    logic          rst_n, start, done, p_wr_en, q_wr_en, rd_v;
    logic [HW-1:0] p_din, q_din;
    logic [AW-1:0] p_wr_addr, q_wr_addr, out_rd_addr, rd_q;
    logic [DW-1:0] u_dout, n_dout, g_dout, lambda_dout;
    logic [DW-1:0] en [16];
    logic [DW-1:0] eg [16];
    logic [DW-1:0] el [16];
    logic [DW-1:0] eu [16];
    bit            known [16];
    int            pv [FS];
    int            qv [FS];
    int            total = 0;
    int            bad = 0;
    int            c1, c2, c3, lows;

    key_generation_top #(.DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW), .FILE_SIZE(FS)) dut (
        .clock(clock), .reset(rst_n), .start(start), .done(done),
        .p_din(p_din), .p_wr_addr(p_wr_addr), .p_wr_en(p_wr_en),
        .q_din(q_din), .q_wr_addr(q_wr_addr), .q_wr_en(q_wr_en),
        .out_rd_addr(out_rd_addr), .u_dout(u_dout), .n_dout(n_dout),
        .g_dout(g_dout), .lambda_dout(lambda_dout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint gcd(input longint x, input longint y);
        longint t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic void model_all();
        for (int i = 0; i < FS; i++) begin
            longint n, l, u;
            n = longint'(pv[i]) * qv[i];
            l = longint'(pv[i] - 1) * (qv[i] - 1);
            u = 0;
            if (l != 0 && n > 1 && gcd(l, n) == 1)
                for (longint x = 1; x < n; x++)
                    if ((l * x) % n == 1) begin
                        u = x;
                        break;
                    end
            en[i] = n[DW-1:0];
            eg[i] = DW'(n + 1);
            el[i] = l[DW-1:0];
            eu[i] = u[DW-1:0];
        end
    endfunction

    // Read port reference: data follows the address captured at the previous rising edge.
    always @(posedge clock or negedge rst_n)
        if (!rst_n) rd_v <= 1'b0;
        else begin
            rd_v <= 1'b1;
            rd_q <= out_rd_addr;
        end

    always @(negedge clock)
        if (!rst_n) begin
            chk("rst_n_dout", n_dout, 0);
            chk("rst_g_dout", g_dout, 0);
            chk("rst_l_dout", lambda_dout, 0);
            chk("rst_u_dout", u_dout, 0);
        end else if (rd_v && known[rd_q]) begin
            chk($sformatf("n[%0d]", rd_q), n_dout, en[rd_q]);
            chk($sformatf("g[%0d]", rd_q), g_dout, eg[rd_q]);
            chk($sformatf("lambda[%0d]", rd_q), lambda_dout, el[rd_q]);
            chk($sformatf("u[%0d]", rd_q), u_dout, eu[rd_q]);
        end

    initial begin
        out_rd_addr = '0;
        forever begin
            @(posedge clock);
            #2 out_rd_addr = out_rd_addr + AW'(1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic write_entry(input int a, input int p, input int q);
        p_wr_addr = AW'(a);
        q_wr_addr = AW'(a);
        p_din     = HW'(p);
        q_din     = HW'(q);
        p_wr_en   = 1'b1;
        q_wr_en   = 1'b1;
        @(posedge clock); #1;
        p_wr_en   = 1'b0;
        q_wr_en   = 1'b0;
    endtask

    task automatic run_batch(input bit pulse, input bit hold, input bit upd, output int cyc);
        start = 1'b1;
        @(posedge clock); #1;
        start = hold;
        cyc = 0;
        chk("done_cleared", done, 0);
        if (upd) begin
            p_wr_addr = AW'(5);
            q_wr_addr = AW'(5);
            p_din     = HW'(7);
            q_din     = HW'(11);
        end
        while (!done && cyc < 4000) begin
            if (pulse) start = (cyc % 7 == 3);
            p_wr_en = upd && cyc == 3;
            q_wr_en = upd && cyc == 3;
            @(posedge clock); #1;
            cyc++;
        end
        p_wr_en = 1'b0;
        q_wr_en = 1'b0;
        if (!hold) start = 1'b0;
        chk("done_raised", done, 1);
    endtask

    task automatic check_lit(input int a, input longint n, input longint g, input longint l, input longint u);
        int k = 0;
        @(negedge clock);
        while (!(rd_v && rd_q == AW'(a)) && k < 40) begin
            @(negedge clock);
            k++;
        end
        chk("lit_wait", k < 40, 1);
        chk($sformatf("lit_n[%0d]", a), n_dout, n);
        chk($sformatf("lit_g[%0d]", a), g_dout, g);
        chk($sformatf("lit_lambda[%0d]", a), lambda_dout, l);
        chk($sformatf("lit_u[%0d]", a), u_dout, u);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        p_wr_en = 1'b0;
        q_wr_en = 1'b0;
        p_din = '0;
        q_din = '0;
        p_wr_addr = '0;
        q_wr_addr = '0;
        pv = '{5, 11, 3, 1, 251, 2};
        qv = '{7, 13, 3, 7, 241, 3};
        repeat (3) @(posedge clock);
        #1;
        chk("reset_done", done, 0);
        chk("reset_u", u_dout, 0);
        rst_n = 1'b1;
        for (int i = 0; i < FS; i++) write_entry(i, pv[i], qv[i]);
        model_all();
        chk("pin_n0", en[0], 35);
        chk("pin_g0", eg[0], 36);
        chk("pin_l0", el[0], 24);
        chk("pin_u0", eu[0], 19);
        chk("pin_n1", en[1], 143);
        chk("pin_u1", eu[1], 87);
        chk("pin_u2", eu[2], 7);
        chk("pin_u3", eu[3], 0);
        chk("pin_u5", eu[5], 0);

        run_batch(1'b1, 1'b0, 1'b0, c1);
        for (int i = 0; i < FS; i++) known[i] = 1'b1;
        check_lit(0, 35, 36, 24, 19);
        check_lit(1, 143, 144, 120, 87);
        check_lit(2, 9, 10, 4, 7);
        check_lit(3, 7, 8, 0, 0);

        run_batch(1'b0, 1'b1, 1'b0, c2);
        chk("busy_start_ignored_cycles", c1, c2);
        lows = 0;
        repeat (100) begin
            @(posedge clock); #1;
            if (!done) lows++;
        end
        chk("held_start_single_run", lows, 0);
        start = 1'b0;

        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (12) @(posedge clock);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_n", n_dout, 0);
        chk("abort_g", g_dout, 0);
        chk("abort_l", lambda_dout, 0);
        chk("abort_u", u_dout, 0);
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        chk("idle_after_abort", done, 0);

        pv[4] = 17;
        qv[4] = 19;
        known[4] = 1'b0;
        write_entry(4, 17, 19);
        pv[5] = 7;
        qv[5] = 11;
        known[5] = 1'b0;
        run_batch(1'b0, 1'b0, 1'b1, c3);
        model_all();
        known[4] = 1'b1;
        known[5] = 1'b1;
        chk("pin_u5_new", eu[5], 9);
        check_lit(5, 77, 78, 60, 9);
        check_lit(4, 323, 324, 288, eu[4]);
        check_lit(0, 35, 36, 24, 19);
        repeat (20) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_generation_top.md
# key_generation_top

Batch Paillier key-generation engine. Host writes up to FILE_SIZE prime pairs (p, q) into two input RAMs and pulses start. For each entry the block computes n, g, lambda and u (mu) and stores them in four output RAMs, then raises done. The host reads results back through a shared read address.

## Interface
- DATA_WIDTH, 1024: key width; p/q are DATA_WIDTH/2 bits, all outputs DATA_WIDTH bits.
- RAM_ADDR_WIDTH, 5: address width of all internal RAMs (depth 2^RAM_ADDR_WIDTH).
- FILE_SIZE, 10: number of entries processed per start (FILE_SIZE ≤ 2^RAM_ADDR_WIDTH).

- clock  in  1  single system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request, sampled in IDLE.
- done  out  1  high when the batch is complete.
- p_din  in  DATA_WIDTH/2  p write data.
- p_wr_addr  in  RAM_ADDR_WIDTH  p write address.
- p_wr_en  in  1  p write enable.
- q_din  in  DATA_WIDTH/2  q write data.
- q_wr_addr  in  RAM_ADDR_WIDTH  q write address.
- q_wr_en  in  1  q write enable.
- out_rd_addr  in  RAM_ADDR_WIDTH  shared read address for all four output RAMs.
- u_dout, n_dout, g_dout, lambda_dout  out  DATA_WIDTH each  registered read data.

## Operation
- Per entry i = 0..FILE_SIZE-1, with p = P[i] and q = Q[i] zero-extended:
  - n = p·q
  - lambda = (p−1)·(q−1)
  - g = n + 1
  - u = lambda⁻¹ mod n
  - If gcd(lambda, n) ≠ 1, or lambda = 0, or n ≤ 1, then u = 0.
- All results are truncated to DATA_WIDTH bits. No overflow occurs for legal p and q.
- Multipliers are shift-and-add, one multiplier bit per cycle. n and lambda are computed in parallel over DATA_WIDTH/2 cycles.
- The inverse uses binary extended Euclid: a = lambda, b = n, x1 = 1, x2 = 0.
  - Halve even a (or b). Halve its coefficient, adding n first if the coefficient is odd.
  - Otherwise subtract the smaller of a, b from the larger, and subtract the matching coefficient mod n.
  - One step per cycle. Stop when a = 1 (u = x1) or b = 1 (u = x2), or when a or b reaches 0 (u = 0).
  - Coefficient datapath is DATA_WIDTH+1 bits.
- FSM states and transitions:
  - IDLE → LOAD on start.
  - LOAD: read P[i] and Q[i] (1-cycle RAM latency) → MUL.
  - MUL: DATA_WIDTH/2 cycles → INV.
  - INV: variable length → WRITE.
  - WRITE: store n, g, lambda, u at address i. Go to LOAD with i+1, or to DONE after the last entry.
  - DONE: done = 1. Holds until the next start, which clears done and goes to LOAD with i = 0.
- start is ignored in every state except IDLE and DONE.
- Input RAM writes are accepted in any state. A write to an entry not yet loaded affects that entry's result.
- Output RAMs are readable in any state. Entries not yet written return their previous contents.
- Reset: FSM → IDLE, i = 0, done = 0, all *_dout = 0. RAM contents are not cleared. A reset mid-batch aborts the batch, and a new start is required.

## Timing
- Input writes are synchronous: a rising edge with wr_en = 1 writes din to wr_addr.
- Output read latency is 1 cycle: *_dout reflects out_rd_addr sampled at the previous rising edge.
- done rises no earlier than the rising edge after the last WRITE.
- Per-entry latency is about 2 (LOAD) + DATA_WIDTH/2 (MUL) + at most 2·DATA_WIDTH (INV) + 1 (WRITE) cycles.
- start is a single-cycle or longer level. Holding start high in DONE restarts the batch exactly once per rising edge of start.

## Test plan
- DATA_WIDTH = 16, entry (p=5, q=7) → n=35, lambda=24, g=36, u=19.
- DATA_WIDTH = 16, entry (p=11, q=13) → n=143, lambda=120, g=144, u=87.
- DATA_WIDTH = 16, degenerate entries:
  - (p=3, q=3) → n=9, lambda=4, g=10, u=7.
  - (p=1, q=7) → n=7, lambda=0, g=8, u=0.
- Default DATA_WIDTH = 1024, FILE_SIZE = 10, random 512-bit primes:
  - lambda_dout matches golden (p−1)(q−1).
  - u·lambda mod n = 1 for every entry.
  - Read data appears one cycle after out_rd_addr changes.
- Apply reset (low) mid-INV:
  - done = 0 and all *_dout = 0 immediately.
  - A new start reprocesses all entries correctly from i = 0.
- start pulses while busy are ignored, with no early done.
- A second start from DONE clears done and recomputes identical results.
